// File: rtl/bus_pkg.sv
// Shared bus definitions: packet width default, ID field layout and broadcast ID.
package bus_pkg;

    localparam int PCKG_SZ = 16;
    localparam int ID_W    = 8;

    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

    // Destination ID lives in the top byte of the packet.
    function automatic logic [ID_W-1:0] get_id(input logic [PCKG_SZ-1:0] pkt);
        return pkt[PCKG_SZ-1 -: ID_W];
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a separate occupancy counter.
// ovf/udf are single-cycle event pulses; the owner decides whether to latch them.
module sync_fifo_fwft #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           din,
    output logic [width-1:0]           dout,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       udf
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth+1);
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(depth));
    assign empty = (count == '0);

    // A pop on an empty FIFO is ignored; a full FIFO still accepts a write
    // when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !pop;
    assign udf     = pop && empty;

    assign dout = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; data is not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bus_port_fifo.sv
// Bus endpoint: TX FIFO drained by the bus, RX FIFO filled by the bus after
// destination-ID filtering, plus sticky error flags and a misroute counter.
module bus_port_fifo
    import bus_pkg::*;
#(
    parameter int              pckg_sz = PCKG_SZ,
    parameter int              depth   = 8,
    parameter logic [ID_W-1:0] drv_id  = 8'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       tx_push,
    input  logic [pckg_sz-1:0]         tx_data,
    output logic                       tx_full,
    output logic [$clog2(depth+1)-1:0] tx_count,
    input  logic                       rx_pop,
    output logic [pckg_sz-1:0]         rx_data,
    output logic                       rx_valid,
    output logic [$clog2(depth+1)-1:0] rx_count,
    output logic                       tx_ovf,
    output logic                       tx_udf,
    output logic                       rx_ovf,
    output logic [ID_W-1:0]            misroute_cnt
);

    localparam logic [ID_W-1:0] CNT_MAX = '1;

    logic            tx_empty;
    logic            tx_ovf_evt;
    logic            tx_udf_evt;
    logic            rx_empty;
    logic            rx_full_unused;
    logic            rx_ovf_evt;
    logic            rx_udf_unused;
    logic [ID_W-1:0] pkt_id;
    logic            accept;

    assign pkt_id   = D_push[pckg_sz-1 -: ID_W];
    assign accept   = (pkt_id == drv_id) || (pkt_id == BCAST_ID);
    assign pndng    = !tx_empty;
    assign rx_valid = !rx_empty;

    sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (D_pop),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty),
        .ovf   (tx_ovf_evt),
        .udf   (tx_udf_evt)
    );

    sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk   (clk),
        .reset (reset),
        .push  (push && accept),
        .pop   (rx_pop),
        .din   (D_push),
        .dout  (rx_data),
        .count (rx_count),
        .full  (rx_full_unused),
        .empty (rx_empty),
        .ovf   (rx_ovf_evt),
        .udf   (rx_udf_unused)
    );

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            tx_udf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_ovf_evt) tx_ovf <= 1'b1;
            if (tx_udf_evt) tx_udf <= 1'b1;
            if (rx_ovf_evt) rx_ovf <= 1'b1;
        end
    end

    // Saturating count of bus packets dropped for a foreign destination ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            misroute_cnt <= '0;
        end else if (push && !accept && misroute_cnt != CNT_MAX) begin
            misroute_cnt <= misroute_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (depth 8, drv_id 3).
module tb_bus_port_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [15:0] D_push = '0;
    logic        tx_push = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_full;
    logic [3:0]  tx_count;
    logic        rx_pop = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [3:0]  rx_count;
    logic        tx_ovf;
    logic        tx_udf;
    logic        rx_ovf;
    logic [7:0]  misroute_cnt;

    int errors = 0;
    int checks = 0;

    bus_port_fifo #(.pckg_sz(16), .depth(8), .drv_id(8'd3)) dut (
        .clk          (clk),
        .reset        (reset),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .tx_push      (tx_push),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .tx_count     (tx_count),
        .rx_pop       (rx_pop),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_count     (rx_count),
        .tx_ovf       (tx_ovf),
        .tx_udf       (tx_udf),
        .rx_ovf       (rx_ovf),
        .misroute_cnt (misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pndng", pndng, 0);
        chk("rst_dpop", D_pop, 0);
        chk("rst_rxvalid", rx_valid, 0);
        chk("rst_rxdata", rx_data, 0);
        chk("rst_txcount", tx_count, 0);
        chk("rst_txfull", tx_full, 0);
        chk("rst_flags", {tx_ovf, tx_udf, rx_ovf}, 0);
        chk("rst_misroute", misroute_cnt, 0);

        // Basic TX write/read
        tx_push = 1'b1; tx_data = 16'h0A11; tick();
        chk("t1_pndng", pndng, 1);
        chk("t1_dpop0", D_pop, 16'h0A11);
        tx_data = 16'h0B22; tick();
        tx_push = 1'b0;
        chk("t1_cnt2", tx_count, 2);
        chk("t1_head", D_pop, 16'h0A11);
        pop = 1'b1; tick();
        chk("t1_dpop1", D_pop, 16'h0B22);
        tick();
        pop = 1'b0;
        chk("t1_empty", pndng, 0);
        chk("t1_dpop_gated", D_pop, 0);
        chk("t1_udf", tx_udf, 0);

        // TX full, overflow, full+push+pop
        tx_push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 16'h1000 + 16'(i);
            tick();
        end
        chk("t2_full", tx_full, 1);
        chk("t2_cnt8", tx_count, 8);
        tx_data = 16'hDEAD; tick();
        chk("t2_ovf", tx_ovf, 1);
        chk("t2_cnt_ovf", tx_count, 8);
        chk("t2_head_ovf", D_pop, 16'h1000);
        tx_data = 16'hBEEF; pop = 1'b1; tick();
        tx_push = 1'b0;
        chk("t2_cnt_pp", tx_count, 8);
        for (int i = 1; i < 9; i++) begin
            chk("t2_drain", D_pop, (i == 8) ? 16'hBEEF : 16'h1000 + 16'(i));
            tick();
        end
        pop = 1'b0;
        chk("t2_drained", pndng, 0);
        chk("t2_udf_clean", tx_udf, 0);
        // Push+pop on empty: push lands, pop flags underflow
        tx_push = 1'b1; pop = 1'b1; tx_data = 16'h5A5A; tick();
        tx_push = 1'b0; pop = 1'b0;
        chk("t2_empty_pp_cnt", tx_count, 1);
        chk("t2_empty_pp_data", D_pop, 16'h5A5A);
        chk("t2_udf", tx_udf, 1);
        pop = 1'b1; tick(); pop = 1'b0;
        chk("t2_final_empty", pndng, 0);

        // RX ID filter
        push = 1'b1;
        D_push = 16'h03AA; tick();
        chk("t3_rx_lat", rx_valid, 1);
        chk("t3_rx_lat_data", rx_data, 16'h03AA);
        D_push = 16'hFF55; tick();
        D_push = 16'h0477; tick();
        push = 1'b0;
        chk("t3_rxcnt", rx_count, 2);
        chk("t3_head0", rx_data, 16'h03AA);
        chk("t3_misroute", misroute_cnt, 1);
        rx_pop = 1'b1; tick();
        chk("t3_head1", rx_data, 16'hFF55);
        tick();
        chk("t3_empty", rx_valid, 0);
        tick();
        rx_pop = 1'b0;
        chk("t3_pop_empty_cnt", rx_count, 0);

        // Misroute saturation
        push = 1'b1; D_push = 16'h0700;
        for (int i = 0; i < 300; i++) tick();
        push = 1'b0;
        chk("t4_sat", misroute_cnt, 8'hFF);
        chk("t4_rxcnt", rx_count, 0);
        chk("t4_rxovf", rx_ovf, 0);

        // RX full, misroute while full, full+accept+rx_pop, overflow
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            D_push = 16'h0300 + 16'(i);
            tick();
        end
        chk("t4_rxfull_cnt", rx_count, 8);
        D_push = 16'h0712; tick();
        chk("t4_full_misroute_ovf", rx_ovf, 0);
        D_push = 16'hFF99; rx_pop = 1'b1; tick();
        rx_pop = 1'b0;
        chk("t4_pp_cnt", rx_count, 8);
        chk("t4_pp_ovf", rx_ovf, 0);
        chk("t4_pp_head", rx_data, 16'h0301);
        D_push = 16'h0342; tick();
        push = 1'b0;
        chk("t4_rxovf_set", rx_ovf, 1);
        chk("t4_ovf_cnt", rx_count, 8);
        chk("t4_ovf_head", rx_data, 16'h0301);

        // Mid-operation reset flushes everything and ignores inputs
        tx_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = 16'h2000 + 16'(i);
            tick();
        end
        tx_push = 1'b0;
        chk("t5_cnt5", tx_count, 5);
        pop = 1'b1; tx_push = 1'b1; tx_data = 16'hAAAA; reset = 1'b1; tick();
        reset = 1'b0; pop = 1'b0; tx_push = 1'b0;
        chk("t5_pndng", pndng, 0);
        chk("t5_cnt", tx_count, 0);
        chk("t5_flags", {tx_ovf, tx_udf, rx_ovf}, 0);
        chk("t5_misroute", misroute_cnt, 0);
        chk("t5_rxcnt", rx_count, 0);
        tx_push = 1'b1; tx_data = 16'h1234; tick();
        tx_push = 1'b0;
        chk("t5_after_data", D_pop, 16'h1234);
        chk("t5_after_cnt", tx_count, 1);
        pop = 1'b1; tick(); pop = 1'b0;
        chk("t5_after_empty", pndng, 0);
        chk("t5_after_udf", tx_udf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
